// File: rtl/pipe_ctrl_hazard.sv
// Purpose : carries decoded control words D->E->M->W and detects load-use hazards.
//           It also applies jump flushes, drives ALU forwarding selects and counts stalls and flushes.
// Latency : one cycle per stage (D->E, E->M, M->W); hazard and forward outputs are combinational.
// Backpr. : only F/D can be held (stall_fd); E takes a bubble, and M/W always advance.
// Ports   : clk/rst_n; D bundle (d_valid, d_ctrl, d_ra1/2, d_wa, d_use1/2); branch_taken;
//           per-stage ctrl/valid, m_wa/w_wa; stall_fd, flush_d, fwd_a/fwd_b; stall_cnt, flush_cnt.
// d_ctrl bit order: {RegWrite,MemtoReg,MemWrite,ALUSrc,FlagsWrite,RegSrc,ALUControl[2:0]}.
module pipe_ctrl_hazard #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_valid,
  input  logic [8:0]       d_ctrl,
  input  logic [RA_W-1:0]  d_ra1,
  input  logic [RA_W-1:0]  d_ra2,
  input  logic [RA_W-1:0]  d_wa,
  input  logic             d_use1,
  input  logic             d_use2,
  input  logic             branch_taken,
  output logic [8:0]       e_ctrl,
  output logic [8:0]       m_ctrl,
  output logic [8:0]       w_ctrl,
  output logic             e_valid,
  output logic             m_valid,
  output logic             w_valid,
  output logic [RA_W-1:0]  m_wa,
  output logic [RA_W-1:0]  w_wa,
  output logic             stall_fd,
  output logic             flush_d,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int REG_WRITE  = 8;
  localparam int MEM_TO_REG = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage E
  logic            e_valid_q, e_valid_d;
  logic [8:0]      e_ctrl_q,  e_ctrl_d;
  logic [RA_W-1:0] e_wa_q,    e_wa_d;
  logic [RA_W-1:0] e_ra1_q,   e_ra1_d;
  logic [RA_W-1:0] e_ra2_q,   e_ra2_d;
  logic            e_use1_q,  e_use1_d;
  logic            e_use2_q,  e_use2_d;
  // Stage M
  logic            m_valid_q, m_valid_d;
  logic [8:0]      m_ctrl_q,  m_ctrl_d;
  logic [RA_W-1:0] m_wa_q,    m_wa_d;
  // Stage W
  logic            w_valid_q, w_valid_d;
  logic [8:0]      w_ctrl_q,  w_ctrl_d;
  logic [RA_W-1:0] w_wa_q,    w_wa_d;
  // Event counters
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic stall_int;
  logic flush_int;

  // Hazard detection. The rst_n gating keeps flush_d at 0 while reset is held,
  // even if branch_taken is driven high upstream.
  always_comb begin
    load_use  = e_valid_q & e_ctrl_q[MEM_TO_REG] & e_ctrl_q[REG_WRITE] & d_valid &
                ((d_use1 & (d_ra1 == e_wa_q)) | (d_use2 & (d_ra2 == e_wa_q)));
    flush_int = rst_n & branch_taken;
    // A taken jump wins: the younger load-dependent instruction is discarded anyway.
    stall_int = rst_n & ~branch_taken & load_use;
  end

  // Next-state for the stage registers and counters.
  always_comb begin
    e_valid_d = 1'b0;
    e_ctrl_d  = '0;
    e_wa_d    = '0;
    e_ra1_d   = '0;
    e_ra2_d   = '0;
    e_use1_d  = 1'b0;
    e_use2_d  = 1'b0;
    // Either a flush or a stall inserts a bubble into E. Otherwise E takes D,
    // but only if D holds a real instruction, so invalid stages stay all-zero.
    if (!flush_int && !stall_int && d_valid) begin
      e_valid_d = 1'b1;
      e_ctrl_d  = d_ctrl;
      e_wa_d    = d_wa;
      e_ra1_d   = d_ra1;
      e_ra2_d   = d_ra2;
      e_use1_d  = d_use1;
      e_use2_d  = d_use2;
    end

    m_valid_d = e_valid_q;
    m_ctrl_d  = e_ctrl_q;
    m_wa_d    = e_wa_q;
    w_valid_d = m_valid_q;
    w_ctrl_d  = m_ctrl_q;
    w_wa_d    = m_wa_q;

    stall_cnt_d = stall_cnt_q;
    if (stall_int && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (flush_int && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Forwarding selects. M is checked first because it holds the newer value.
  // A load sitting in M has no data yet, so it is excluded; load_use has
  // already separated it from its consumer by one cycle.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (e_valid_q && e_use1_q) begin
      if (m_valid_q && m_ctrl_q[REG_WRITE] && !m_ctrl_q[MEM_TO_REG] && (m_wa_q == e_ra1_q)) begin
        fwd_a = 2'b10;
      end else if (w_valid_q && w_ctrl_q[REG_WRITE] && (w_wa_q == e_ra1_q)) begin
        fwd_a = 2'b01;
      end
    end
    if (e_valid_q && e_use2_q) begin
      if (m_valid_q && m_ctrl_q[REG_WRITE] && !m_ctrl_q[MEM_TO_REG] && (m_wa_q == e_ra2_q)) begin
        fwd_b = 2'b10;
      end else if (w_valid_q && w_ctrl_q[REG_WRITE] && (w_wa_q == e_ra2_q)) begin
        fwd_b = 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_q   <= 1'b0;
      e_ctrl_q    <= '0;
      e_wa_q      <= '0;
      e_ra1_q     <= '0;
      e_ra2_q     <= '0;
      e_use1_q    <= 1'b0;
      e_use2_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      m_ctrl_q    <= '0;
      m_wa_q      <= '0;
      w_valid_q   <= 1'b0;
      w_ctrl_q    <= '0;
      w_wa_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_valid_q   <= e_valid_d;
      e_ctrl_q    <= e_ctrl_d;
      e_wa_q      <= e_wa_d;
      e_ra1_q     <= e_ra1_d;
      e_ra2_q     <= e_ra2_d;
      e_use1_q    <= e_use1_d;
      e_use2_q    <= e_use2_d;
      m_valid_q   <= m_valid_d;
      m_ctrl_q    <= m_ctrl_d;
      m_wa_q      <= m_wa_d;
      w_valid_q   <= w_valid_d;
      w_ctrl_q    <= w_ctrl_d;
      w_wa_q      <= w_wa_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Stage registers are already zero when invalid; the valid gating keeps
  // that guarantee explicit at the ports.
  assign e_ctrl    = e_valid_q ? e_ctrl_q : '0;
  assign m_ctrl    = m_valid_q ? m_ctrl_q : '0;
  assign w_ctrl    = w_valid_q ? w_ctrl_q : '0;
  assign e_valid   = e_valid_q;
  assign m_valid   = m_valid_q;
  assign w_valid   = w_valid_q;
  assign m_wa      = m_wa_q;
  assign w_wa      = w_wa_q;
  assign stall_fd  = stall_int;
  assign flush_d   = flush_int;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
